// File: rtl/alu_pkg.sv
// Shared opcode encodings, handshake FSM states and opcode helpers for alu_mc.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter(input logic [3:0] sel);
        return (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative engine: shift-add multiplier and restoring divider, one step per cycle.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    count;
    logic [3:0]       op_q;
    // x: multiplicand / dividend-then-quotient, y: multiplier / divisor, p: product / remainder
    logic [WIDTH-1:0] x_q, y_q, p_q;
    logic [WIDTH-1:0] x_nxt, y_nxt, p_nxt;
    logic [WIDTH:0]   rem_sh, diff;

    always_comb begin
        rem_sh = {p_q, x_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, y_q};
        x_nxt  = x_q;
        y_nxt  = y_q;
        p_nxt  = p_q;
        if (op_q == OP_MUL) begin
            p_nxt = p_q + (y_q[0] ? x_q : '0);
            x_nxt = x_q << 1;
            y_nxt = y_q >> 1;
        end else if (!diff[WIDTH]) begin
            // A zero divisor always takes this branch: quotient all-ones, remainder = dividend
            p_nxt = diff[WIDTH-1:0];
            x_nxt = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            p_nxt = rem_sh[WIDTH-1:0];
            x_nxt = {x_q[WIDTH-2:0], 1'b0};
        end
        result = (op_q == OP_DIVU) ? x_nxt : p_nxt;
        done   = busy && (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            op_q  <= OP_MUL;
            x_q   <= '0;
            y_q   <= '0;
            p_q   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            op_q  <= op;
            x_q   <= a;
            y_q   <= b;
            p_q   <= '0;
        end else if (busy) begin
            x_q <= x_nxt;
            y_q <= y_nxt;
            p_q <= p_nxt;
            if (done) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshake FSM, single-cycle datapath and registered result.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_zero
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic             iter_start, single_xfer, iter_done;
    logic [WIDTH-1:0] alu_res, iter_res;
    logic [SH_W-1:0]  shamt;

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .op     (sel),
        .a      (in0),
        .b      (in1),
        .result (iter_res),
        .done   (iter_done)
    );

    always_comb begin
        shamt   = in1[SH_W-1:0];
        alu_res = '0;
        case (sel)
            OP_ADD:  alu_res = in0 + in1;
            OP_SUB:  alu_res = in0 - in1;
            OP_AND:  alu_res = in0 & in1;
            OP_OR:   alu_res = in0 | in1;
            OP_XOR:  alu_res = in0 ^ in1;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in0 < in1)};
            OP_SLL:  alu_res = in0 << shamt;
            OP_SRL:  alu_res = in0 >> shamt;
            OP_SRA:  alu_res = $signed(in0) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        iter_start  = 1'b0;
        single_xfer = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_iter(sel)) begin
                        iter_start = 1'b1;
                        state_nxt  = ST_RUN;
                    end else begin
                        single_xfer = 1'b1;
                    end
                end
            end
            ST_RUN:  if (iter_done) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_zero  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (single_xfer) begin
                out       <= alu_res;
                out_zero  <= (alu_res == '0);
                out_valid <= 1'b1;
            end else if ((state == ST_RUN) && iter_done) begin
                out       <= iter_res;
                out_zero  <= (iter_res == '0);
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU: the successor to the combinational 3-bit-select ALU in the single-cycle datapath. It keeps the ADD/SUB/AND/OR encodings and adds XOR, compares, shifts, and iterative MUL/DIVU/REMU. It registers every result and exchanges operands and results over a valid/ready handshake, so the upcoming multi-cycle core can stall on long operations.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8
- SEL_W, 4: opcode width; fixed at 4 for the encodings below
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and opcode present
- in_ready  output  1  block can accept an operation this cycle
- in0, in1  input  WIDTH  operands
- sel  input  SEL_W  opcode
- out_valid  output  1  one-cycle pulse: out/out_zero hold a new result
- out  output  WIDTH  registered result; held until the next result
- out_zero  output  1  registered, equals (out == 0)

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR (unchanged from the 3-bit ALU)
  - 0100 XOR
  - 0101 SLT (signed), 0110 SLTU: result 1 or 0, zero-extended
  - 0111 SLL, 1000 SRL, 1001 SRA: shift amount is in1[log2(WIDTH)-1:0]
  - 1010 MUL: low WIDTH bits of the unsigned product
  - 1011 DIVU, 1100 REMU: unsigned
- Reserved opcodes 1101–1111: accepted as single-cycle ops; out = 0, out_zero = 1. Never X.
- ADD/SUB wrap modulo 2^WIDTH. No carry or overflow output.
- DIVU with in1 = 0: quotient all-ones. REMU with in1 = 0: remainder in0.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready = 1. A transfer is in_valid && in_ready.
  - Single-cycle op transfer: result registered at that edge; out_valid next cycle; stay IDLE, so back-to-back issue is allowed.
  - Iterative op (MUL/DIVU/REMU) transfer: latch operands and opcode, counter = 0, go to RUN.
  - RUN: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle. After WIDTH steps, register the result and go to DONE.
  - DONE: out_valid = 1, in_ready = 0; next state IDLE.
- in_ready = 0 in RUN and DONE. in_valid in those states is ignored and not queued.
- Inputs are sampled only at the transfer edge. Later changes to in0/in1/sel do not affect an operation in flight.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, out = 0, out_zero = 1, counter = 0.
- Single-cycle op transferred at edge N: out_valid high during cycle N+1.
- Iterative op transferred at edge N:
  - RUN occupies cycles N+1 … N+WIDTH.
  - out_valid high during cycle N+WIDTH+1 (DONE).
  - in_ready high again at cycle N+WIDTH+2.
- out_valid is never high two cycles in a row for an iterative op. Back-to-back single-cycle ops pulse on consecutive cycles.
- rst asserted mid-RUN or mid-DONE: immediate return to reset values. No out_valid for the aborted op.
- out and out_zero change only on edges where out_valid is set, or on reset.

## Structure
- Package alu_pkg holds:
  - the opcode localparams (OP_ADD … OP_REMU)
  - the FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
  - the function is_iter(sel)
- Sub-module alu_iter_unit (WIDTH): shared shift-add multiplier and restoring divider.
  - Inputs: start, op, a, b.
  - Outputs: result, done (asserted after WIDTH steps).
  - alu_mc owns the handshake FSM and the single-cycle datapath.

## Test plan
- Reset, then check idle outputs; then ADD 0xFFFFFFFF + 1 (WIDTH = 32) → out_valid at N+1, out = 0, out_zero = 1.
- Back-to-back SUB 5−7 then SLT 0x80000000 vs 1, on consecutive cycles → out = 0xFFFFFFFE, then out = 1. out_valid pulses on two adjacent cycles.
- SRA 0x80000000 by in1 = 0x21 (amount 1) → 0xC0000000. SRL of the same operands → 0x40000000.
- MUL 0x10001 × 0x10001 → out = 0x00020001 at exactly N+33. in_ready low during N+1 … N+33. An in_valid pulse in that window is ignored.
- DIVU 100 / 7 → 14; REMU 100 / 7 → 2. DIVU x / 0 → 0xFFFFFFFF; REMU 9 / 0 → 9.
- Reserved opcode 1111 → out = 0, out_zero = 1. MUL started, then rst pulsed at RUN cycle 10 → no out_valid, reset values restored, and the next ADD completes normally.
